// File: rtl/inst_buf_pkg.sv
// Shared defaults and field layout for the instruction buffer.
// The optional INST_BUF_PARITY_EN macro is consumed by inst_buf.sv.
package inst_buf_pkg;

  localparam int DEF_INST_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_OPC_WIDTH  = 8;
  localparam int DEF_IMME_WIDTH = 16;

  // Opcode is counted down from the instruction MSB, immediate up from the LSB.
  localparam int OPC_MSB_OFS = 0;
  localparam int IMME_LSB    = 0;

endpackage

// File: rtl/inst_buf_mem.sv
// Instruction buffer storage: synchronous write, asynchronous read, no reset.
module inst_buf_mem #(
  parameter int DW    = 33,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/inst_buf.sv
// Instruction FIFO between fetch and decode with ack-pulsed push/pop handshakes.
// Define INST_BUF_PARITY_EN to store and check an even-parity bit per entry.
module inst_buf
  import inst_buf_pkg::*;
#(
  parameter int PA_INST_WIDTH = DEF_INST_WIDTH,
  parameter int PA_DEPTH      = DEF_DEPTH,
  parameter int PA_OPC_WIDTH  = DEF_OPC_WIDTH,
  parameter int PA_IMME_WIDTH = DEF_IMME_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [PA_INST_WIDTH-1:0]   ir_in,
  input  logic                       ir_wr,
  output logic                       ir_wr_ack,
  input  logic                       dec_req,
  output logic                       dec_ack,
  input  logic                       flush,
  output logic [PA_INST_WIDTH-1:0]   instr_out,
  output logic [PA_OPC_WIDTH-1:0]    opcode,
  output logic [PA_IMME_WIDTH-1:0]   imme_out,
  output logic                       instr_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(PA_DEPTH):0]  count,
  output logic                       par_err
);

  localparam int AW = $clog2(PA_DEPTH);
  localparam int CW = AW + 1;
`ifdef INST_BUF_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = PA_INST_WIDTH + PW;

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          wr_ack_r, dec_ack_r, par_err_r;
  logic          push_s, pop_s, empty_s, full_s, par_bad_s;
  logic [MW-1:0] wdata_s, rdata_s;

`ifdef INST_BUF_PARITY_EN
  function automatic logic even_par(input logic [PA_INST_WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  // Handshake qualification; a pop frees the slot a same-edge push fills when full.
  always_comb begin
    empty_s = (count_r == {CW{1'b0}});
    full_s  = (count_r == CW'(PA_DEPTH));
    pop_s   = dec_req & ~empty_s & ~dec_ack_r & ~flush;
    push_s  = ir_wr & (~full_s | pop_s) & ~wr_ack_r & ~flush;
`ifdef INST_BUF_PARITY_EN
    wdata_s   = {even_par(ir_in), ir_in};
    par_bad_s = pop_s & (rdata_s[MW-1] != even_par(rdata_s[PA_INST_WIDTH-1:0]));
`else
    wdata_s   = ir_in;
    par_bad_s = 1'b0;
`endif
  end

  inst_buf_mem #(.DW(MW), .DEPTH(PA_DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Pointers, occupancy, ack pulses and sticky parity error; flush overrides all.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      wr_ack_r  <= 1'b0;
      dec_ack_r <= 1'b0;
      par_err_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      wr_ack_r  <= 1'b0;
      dec_ack_r <= 1'b0;
      par_err_r <= 1'b0;
    end else begin
      wr_ack_r  <= push_s;
      dec_ack_r <= pop_s;
      par_err_r <= par_err_r | par_bad_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      else        rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign instr_out   = rdata_s[PA_INST_WIDTH-1:0];
  assign opcode      = instr_out[PA_INST_WIDTH-1-OPC_MSB_OFS -: PA_OPC_WIDTH];
  assign imme_out    = instr_out[IMME_LSB +: PA_IMME_WIDTH];
  assign instr_valid = ~empty_s;
  assign empty       = empty_s;
  assign full        = full_s;
  assign count       = count_r;
  assign ir_wr_ack   = wr_ack_r;
  assign dec_ack     = dec_ack_r;
  assign par_err     = par_err_r;

endmodule

// File: tb/tb_inst_buf.sv
// Self-checking bench for inst_buf: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_inst_buf;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] ir_in;
  logic        ir_wr, dec_req, flush;
  logic        ir_wr_ack, dec_ack;
  logic [31:0] instr_out;
  logic [7:0]  opcode;
  logic [15:0] imme_out;
  logic        instr_valid, full, empty, par_err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit m_wr_ack, m_dec_ack, m_par, m_corrupt_head;

  always #5 clk = ~clk;

  inst_buf dut (
    .clk(clk), .rst_b(rst_b), .ir_in(ir_in), .ir_wr(ir_wr), .ir_wr_ack(ir_wr_ack),
    .dec_req(dec_req), .dec_ack(dec_ack), .flush(flush), .instr_out(instr_out),
    .opcode(opcode), .imme_out(imme_out), .instr_valid(instr_valid), .full(full),
    .empty(empty), .count(count), .par_err(par_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ir_wr_ack", {31'd0, ir_wr_ack}, {31'd0, m_wr_ack});
    chk("dec_ack", {31'd0, dec_ack}, {31'd0, m_dec_ack});
    chk("count", {29'd0, count}, q.size());
    chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("full", {31'd0, full}, {31'd0, q.size() == 4});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
    chk("par_err", {31'd0, par_err}, {31'd0, m_par});
    if (q.size() != 0) begin
      chk("instr_out", instr_out, q[0]);
      chk("opcode", {24'd0, opcode}, {24'd0, q[0][31:24]});
      chk("imme_out", {16'd0, imme_out}, {16'd0, q[0][15:0]});
    end
  endtask

  // One clock: apply inputs, predict the edge from the buffer rules, then check.
  task automatic step(input logic wr, input logic [31:0] din, input logic rq, input logic fl);
    bit do_pop, do_push;
    ir_wr = wr; ir_in = din; dec_req = rq; flush = fl;
    do_pop  = rq && !fl && !m_dec_ack && (q.size() != 0);
    do_push = wr && !fl && !m_wr_ack && ((q.size() < 4) || do_pop);
    if (fl) begin
      q.delete();
      m_par = 1'b0;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        if (m_corrupt_head) m_par = 1'b1;
        m_corrupt_head = 1'b0;
      end
      if (do_push) q.push_back(din);
    end
    m_wr_ack  = do_push;
    m_dec_ack = do_pop;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bit          wr_pend, rq_pend;
    logic [31:0] pend_data;
    logic [31:0] words [6];
    rst_b = 1'b0; ir_wr = 1'b0; dec_req = 1'b0; flush = 1'b0; ir_in = 32'd0;
    m_wr_ack = 1'b0; m_dec_ack = 1'b0; m_par = 1'b0; m_corrupt_head = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_b = 1'b1;

    // Single push: ack one cycle later, fields decoded from the head.
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    chk("first_opcode", {24'd0, opcode}, 32'h0000_0012);
    chk("first_imme", {16'd0, imme_out}, 32'h0000_5678);
    chk("first_count", {29'd0, count}, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill to four, then hold a fifth push against a full buffer.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 32'hBEEF_0005, 1'b0, 1'b0);
    chk("full_stall_full", {31'd0, full}, 32'd1);
    chk("full_stall_ack", {31'd0, ir_wr_ack}, 32'd0);
    step(1'b1, 32'hBEEF_0005, 1'b1, 1'b0);
    chk("full_pushpop_count", {29'd0, count}, 32'd4);
    chk("full_pushpop_wack", {31'd0, ir_wr_ack}, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Drain, then hammer dec_req on an empty buffer.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("empty_req_noack", {31'd0, dec_ack}, 32'd0);
    step(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Three entries then flush with coincident push and pop.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
    end
    step(1'b1, 32'hDEAD_DEAD, 1'b1, 1'b1);
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Six push/pop pairs wrap both pointers; data must come back in order.
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, words[i], 1'b0, 1'b0);
      chk("wrap_head", instr_out, words[i]);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
    end

    // Reset mid-handshake: the pending ack is abandoned.
    step(1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
    ir_wr = 1'b0;
    rst_b = 1'b0;
    #1;
    q.delete(); m_wr_ack = 1'b0; m_dec_ack = 1'b0; m_par = 1'b0;
    check_all();
    #2;
    rst_b = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);

`ifdef INST_BUF_PARITY_EN
    // Corrupt the stored head word and pop it: par_err must stick until flush.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'hA5A5_0F0F, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    dut.u_mem.mem_r[0] = dut.u_mem.mem_r[0] ^ 33'h0_0000_0001;
    m_corrupt_head = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("par_err_set", {31'd0, par_err}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("par_err_flush", {31'd0, par_err}, 32'd0);
`endif

    // Randomized traffic honouring the hold-until-ack protocol.
    wr_pend = 1'b0; rq_pend = 1'b0; pend_data = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (!wr_pend && ($urandom_range(0, 1) == 1)) begin
        wr_pend = 1'b1;
        pend_data = $urandom;
      end
      if (!rq_pend && ($urandom_range(0, 2) != 0)) rq_pend = 1'b1;
      step(wr_pend, pend_data, rq_pend, $urandom_range(0, 31) == 0);
      if (m_wr_ack) wr_pend = 1'b0;
      if (m_dec_ack) rq_pend = 1'b0;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
